// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the two-digit BCD display scanner:
//   - scan_state_t : which digit slot (if any) the scanner is driving
//   - SEG_*        : active-high seven-segment codes, bit 0 = a ... bit 6 = g
//   - has_bad_nibble() : true when either BCD nibble of a word exceeds 9
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DIG0 = 2'd1,
        S_DIG1 = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic has_bad_nibble(input logic [7:0] word);
        return (word[7:4] > 4'd9) || (word[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner_if
// Groups the data/strobe inputs and display outputs of the scanner.
//   bcd_in [7:0] : [7:4] tens, [3:0] ones
//   load         : one-cycle capture strobe
//   enable       : 0 turns the display off
//   seg    [6:0] : segment bus, seg[0]=a ... seg[6]=g
//   an     [1:0] : active-low digit selects, an[0]=ones, an[1]=tens
//   err          : sticky invalid-BCD flag of the committed word
// master : the upstream source / board side; slave : the scanner.
// -----------------------------------------------------------------------------
interface bcd_display_scanner_if;

    logic [7:0] bcd_in;
    logic       load;
    logic       enable;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (
        output bcd_in,
        output load,
        output enable,
        input  seg,
        input  an,
        input  err
    );

    modport slave (
        input  bcd_in,
        input  load,
        input  enable,
        output seg,
        output an,
        output err
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational nibble to seven-segment decoder, active-high output.
//   digit [3:0] : BCD nibble; 10..15 render as "E"
//   code  [6:0] : segment pattern, bit 0 = a ... bit 6 = g
// -----------------------------------------------------------------------------
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_E;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
// Time-multiplexes a two-digit BCD word onto a pair of 7-segment displays that
// share one segment bus. New values are captured on load into a pending
// register and committed only when a scan frame restarts (S_DIG1->S_DIG0 or
// S_OFF->S_DIG0), so a frame never shows digits from two different words.
//
// Parameters:
//   REFRESH_DIV        : clk cycles per digit slot (>= 2)
//   BLANK_LEADING_ZERO : 1 blanks a zero tens digit (slot length unchanged)
//   SEG_ACTIVE_LOW     : 1 inverts the segment bus
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_display_scanner_if.slave (bcd_in, load, enable, seg, an, err)
// -----------------------------------------------------------------------------
module bcd_display_scanner
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV        = 50000,
    parameter bit          BLANK_LEADING_ZERO = 1'b1,
    parameter bit          SEG_ACTIVE_LOW     = 1'b1
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_display_scanner_if.slave   bus
);

    localparam int unsigned      CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       comm_q, comm_d;
    logic             err_q, err_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic             tick;
    logic             commit;
    logic             tens_blank;
    logic [3:0]       digit_sel;
    logic [6:0]       digit_code;
    logic [6:0]       seg_raw;

    // ------------------------------------------------------------------
    // Scan FSM and refresh counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        tick    = (cnt_q == CNT_MAX);

        if (!bus.enable) begin
            // Disable wins over tick in every state.
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_DIG0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
                S_DIG0: begin
                    if (tick) begin
                        state_d = S_DIG1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DIG1: begin
                    if (tick) begin
                        state_d = S_DIG0;
                        cnt_d   = '0;
                        commit  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending / committed word and sticky error
    // ------------------------------------------------------------------
    always_comb begin
        pend_d       = bus.load ? bus.bcd_in : pend_q;
        pend_valid_d = pend_valid_q;
        comm_d       = comm_q;
        err_d        = err_q;

        // pend_d already folds in a same-cycle load, so a load on the commit
        // edge commits bcd_in directly and leaves pend_valid clear.
        if (commit && (pend_valid_q || bus.load)) begin
            comm_d       = pend_d;
            pend_valid_d = 1'b0;
            err_d        = has_bad_nibble(pend_d);
        end else if (bus.load) begin
            pend_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display mux, decode and polarity
    // ------------------------------------------------------------------
    // Outputs are derived from next-state values so that an, seg and the
    // scan state all update on the same edge.
    always_comb begin
        tens_blank = BLANK_LEADING_ZERO && (comm_d[7:4] == 4'd0);
        digit_sel  = (state_d == S_DIG1) ? comm_d[7:4] : comm_d[3:0];
    end

    bcd_to_7seg u_dec (
        .digit (digit_sel),
        .code  (digit_code)
    );

    always_comb begin
        an_d    = 2'b11;
        seg_raw = SEG_BLANK;
        case (state_d)
            S_DIG0: begin
                an_d    = 2'b10;
                seg_raw = digit_code;
            end
            S_DIG1: begin
                if (tens_blank) begin
                    an_d    = 2'b11;
                    seg_raw = SEG_BLANK;
                end else begin
                    an_d    = 2'b01;
                    seg_raw = digit_code;
                end
            end
            default: begin
                an_d    = 2'b11;
                seg_raw = SEG_BLANK;
            end
        endcase
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            comm_q       <= '0;
            err_q        <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= 2'b11;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            comm_q       <= comm_d;
            err_q        <= err_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
// Directed walk through the display scenarios followed by randomized traffic,
// all compared against a slot/age model of the scanner.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;

    bcd_display_scanner_if dif ();

    bcd_display_scanner #(
        .REFRESH_DIV        (DIV),
        .BLANK_LEADING_ZERO (1'b1),
        .SEG_ACTIVE_LOW     (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Active-high digit glyphs indexed by nibble value.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

    // Model: slot 0 = dark, 1 = ones, 2 = tens; age = cycles spent in slot.
    int         m_slot;
    int         m_age;
    logic [7:0] m_pend;
    logic [7:0] m_comm;
    logic       m_err;

    task automatic model_reset();
        m_slot = 0;
        m_age  = 0;
        m_pend = 8'h00;
        m_comm = 8'h00;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        bit frame_start;
        frame_start = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!dif.enable) begin
                m_slot = 0;
                m_age  = 0;
            end else if (m_slot == 0) begin
                m_slot = 1;
                m_age  = 0;
                frame_start = 1;
            end else if (m_age == DIV - 1) begin
                frame_start = (m_slot == 2);
                m_slot = (m_slot == 1) ? 2 : 1;
                m_age  = 0;
            end else begin
                m_age = m_age + 1;
            end
            if (dif.load) m_pend = dif.bcd_in;
            if (frame_start) begin
                m_comm = m_pend;
                m_err  = (m_comm[7:4] > 9) || (m_comm[3:0] > 9);
            end
        end
    endtask

    task automatic model_outputs(output logic [6:0] es, output logic [1:0] ea);
        if (m_slot == 1) begin
            ea = 2'b10;
            es = ~glyph[m_comm[3:0]];
        end else if (m_slot == 2 && m_comm[7:4] != 4'd0) begin
            ea = 2'b01;
            es = ~glyph[m_comm[7:4]];
        end else begin
            ea = 2'b11;
            es = 7'h7F;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [6:0] es;
        logic [1:0] ea;
        model_outputs(es, ea);
        check({tag, ".seg"}, {1'b0, dif.seg}, {1'b0, es});
        check({tag, ".an"},  {6'b0, dif.an},  {6'b0, ea});
        check({tag, ".err"}, {7'b0, dif.err}, {7'b0, m_err});
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic load_cycle(input logic [7:0] value, input string tag);
        dif.load   = 1'b1;
        dif.bcd_in = value;
        cycle(tag);
        dif.load   = 1'b0;
    endtask

    task automatic run_until(input int slot, input int age, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(tag);
            if (m_slot == slot && m_age == age) found = 1;
        end
        check({tag, ".reached"}, {7'b0, found}, 8'h01);
    endtask

    initial begin
        rst_n      = 1'b0;
        dif.enable = 1'b0;
        dif.load   = 1'b0;
        dif.bcd_in = 8'h00;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.an",  {6'b0, dif.an},  8'h03);
        check("rst.seg", {1'b0, dif.seg}, 8'h7F);
        check("rst.err", {7'b0, dif.err}, 8'h00);

        // Release with enable: ones slot showing 0, then blanked tens slot
        rst_n      = 1'b1;
        dif.enable = 1'b1;
        cycle("start");
        check("start.an",  {6'b0, dif.an},  8'h02);
        check("start.seg", {1'b0, dif.seg}, 8'h40);
        repeat (3) cycle("slot0");
        cycle("slot1");
        check("blank0.an", {6'b0, dif.an}, 8'h03);

        // 07 shows on the next ones slot, tens stays blanked
        load_cycle(8'h07, "ld07");
        run_until(1, 0, "w07");
        check("v07.seg", {1'b0, dif.seg}, 8'h78);
        check("v07.an",  {6'b0, dif.an},  8'h02);
        run_until(2, 0, "w07t");
        check("v07t.an", {6'b0, dif.an}, 8'h03);

        // 15 loaded mid ones slot: old value held until the frame ends
        run_until(1, 1, "w15a");
        load_cycle(8'h15, "ld15");
        check("hold07.seg", {1'b0, dif.seg}, 8'h78);
        run_until(2, 0, "w15b");
        check("hold07t.an", {6'b0, dif.an}, 8'h03);
        run_until(1, 0, "w15c");
        check("v15.seg", {1'b0, dif.seg}, 8'h12);
        run_until(2, 0, "w15d");
        check("v15t.seg", {1'b0, dif.seg}, 8'h79);
        check("v15t.an",  {6'b0, dif.an},  8'h01);

        // Invalid nibble sets err and shows E; a valid word clears it
        load_cycle(8'h1C, "ld1C");
        run_until(1, 0, "w1C");
        check("v1C.err", {7'b0, dif.err}, 8'h01);
        check("v1C.seg", {1'b0, dif.seg}, 8'h06);
        load_cycle(8'h03, "ld03");
        run_until(1, 0, "w03");
        check("v03.err", {7'b0, dif.err}, 8'h00);
        check("v03.seg", {1'b0, dif.seg}, 8'h30);

        // Enable dropped for three cycles, then the slot restarts from zero
        dif.enable = 1'b0;
        cycle("off");
        check("off.an",  {6'b0, dif.an},  8'h03);
        check("off.seg", {1'b0, dif.seg}, 8'h7F);
        repeat (2) cycle("off");
        dif.enable = 1'b1;
        cycle("reon");
        check("reon.an", {6'b0, dif.an}, 8'h02);
        for (int i = 0; i < DIV - 1; i++) begin
            cycle("reon.hold");
            check("reon.hold.an", {6'b0, dif.an}, 8'h02);
        end
        cycle("reon.end");
        check("reon.end.an", {6'b0, dif.an}, 8'h03);

        // Back-to-back loads, the second on the frame-restart edge
        run_until(2, 2, "wbb");
        load_cycle(8'h02, "ld02");
        load_cycle(8'h09, "ld09");
        check("v09.seg", {1'b0, dif.seg}, 8'h10);
        check("v09.an",  {6'b0, dif.an},  8'h02);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            dif.enable = ($urandom_range(0, 15) != 0);
            dif.load   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                dif.bcd_in = 8'($urandom);
            else
                dif.bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            cycle("rand");
        end
        dif.load   = 1'b0;
        dif.enable = 1'b1;

        // Reset mid-slot takes effect without a clock edge
        load_cycle(8'h42, "ld42");
        run_until(2, 1, "w42");
        check("pre_rst.an", {6'b0, dif.an}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        check("arst.an",  {6'b0, dif.an},  8'h03);
        check("arst.seg", {1'b0, dif.seg}, 8'h7F);
        check("arst.err", {7'b0, dif.err}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst");
        check("post_rst.seg", {1'b0, dif.seg}, 8'h40);
        repeat (2 * DIV) cycle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the 4-bit binary-to-BCD converter.
- Takes the 8-bit two-digit BCD word and drives a time-multiplexed pair of 7-segment displays through a shared segment bus.
- Captures new values on a load strobe and commits them only at a scan-frame boundary, so the display never tears.
- Sits between the converter output and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot (1 kHz per slot at 50 MHz); minimum 2.
- BLANK_LEADING_ZERO, 1: when 1, a zero tens digit is blanked.
- SEG_ACTIVE_LOW, 1: when 1, seg outputs are inverted (a 0 lights a segment).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- bcd_in, input, 8: [7:4] tens digit, [3:0] ones digit.
- load, input, 1: one-cycle strobe; capture bcd_in.
- enable, input, 1: 0 turns the display off.
- seg, output, 7: segments; seg[0]=a … seg[6]=g; polarity set by SEG_ACTIVE_LOW.
- an, output, 2: digit selects, active-low; an[0]=ones, an[1]=tens.
- err, output, 1: sticky; the committed word contains a nibble greater than 9.

Behaviour:
- Reset (async, rst_n=0):
  - State S_OFF; refresh counter 0.
  - Pending and committed registers 8'h00; pend_valid 0.
  - an=2'b11, seg = all segments off (7'h7F if SEG_ACTIVE_LOW, else 7'h00), err=0.
  - All outputs registered; reset may assert at any cycle and takes effect immediately.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 while state is not S_OFF, then wraps.
  - tick = counter at REFRESH_DIV-1.
  - Cleared on entry to S_OFF.
- FSM states:
  - S_OFF: an=11, segments off. If enable=1, go to S_DIG0 on the next edge.
  - S_DIG0: an=10, ones digit shown. On tick, go to S_DIG1.
  - S_DIG1: an=01, tens digit shown. On tick, go to S_DIG0.
  - enable=0 in any state goes to S_OFF on the next edge and has priority over tick.
- Load/commit:
  - load=1 captures bcd_in into the pending register and sets pend_valid. Multiple loads before a commit: the last one wins.
  - Commit happens on the S_DIG1→S_DIG0 transition, and on S_OFF→S_DIG0: committed ← pending, pend_valid ← 0.
  - If load coincides with a commit edge, bcd_in itself is committed and pend_valid stays 0.
  - Latency from load to visible change: at most 2·REFRESH_DIV+1 cycles.
- Decode, per nibble (active-high codes):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10–15 display "E" (79).
  - Invert all codes if SEG_ACTIVE_LOW.
- err:
  - Set on a commit whose word has either nibble greater than 9.
  - Cleared on a commit of a fully valid word.
  - Unaffected by enable.
- Leading-zero blanking:
  - Applies when BLANK_LEADING_ZERO=1 and committed tens nibble = 0.
  - The S_DIG1 slot drives an=11 and segments off, but still lasts REFRESH_DIV cycles.
  - The ones digit is never blanked.
- Output timing: seg and an are registered together, so the digit select and segment pattern change on the same edge; no glitch between digits.

Decomposition:
- Package disp_pkg holds:
  - state enum scan_state_t {S_OFF, S_DIG0, S_DIG1};
  - the seven-segment code constants (SEG_0..SEG_9, SEG_E, SEG_BLANK).
- Sub-module bcd_to_7seg: combinational 4-bit nibble → 7-bit active-high code, with "E" for 10–15.
  - Instantiate it once on the digit selected by the mux.
  - Polarity inversion is done in the parent.

Test Plan (REFRESH_DIV=4, BLANK_LEADING_ZERO=1, SEG_ACTIVE_LOW=1):
- Reset, then release with enable=1:
  - During reset: an=11, seg=7F, err=0.
  - One cycle after release: an=10, seg=40 ("0").
  - After 4 cycles: an=11 (tens blanked).
- load with bcd_in=8'h07:
  - Appears at the next S_DIG0 entry as seg=78 on an=10.
  - Tens slot stays blanked.
- load 8'h15 mid S_DIG0:
  - Display keeps the old value until S_DIG1 ends.
  - Then ones slot shows seg=12 (5), tens slot shows seg=79 (1) on an=01.
- load 8'h1C:
  - After commit, err=1 and ones slot shows seg=06 ("E").
  - Then load 8'h03: after commit, err=0.
- Drop enable for 3 cycles:
  - an=11, seg=7F on the next edge.
  - Re-enable: S_DIG0 with counter restarted at 0.
- Loads of 8'h02 then 8'h09 in consecutive cycles, with the second load coinciding with a S_DIG1→S_DIG0 tick:
  - Ones slot shows 9 (seg=10) immediately after that edge.
- Reset asserted mid-slot:
  - Outputs go to reset values asynchronously, without waiting for a clock edge.
